// File: rtl/viterbi_seq_ctrl.sv
// viterbi_seq_ctrl: sequencing controller for a serial-ACS Viterbi decoder.
// It walks the ACS unit through every trellis state once per symbol pair.
// It manages the survivor-memory write column. Once the memory holds a full
// traceback window, it traces back from the best state and hands out one
// decoded bit per symbol.
module viterbi_seq_ctrl #(
  parameter  int K    = 5,
  parameter  int D_TB = 32,
  localparam int NS   = 1 << (K - 1),
  localparam int SW   = K - 1,
  localparam int AW   = $clog2(D_TB)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          acs_en,
  output logic [SW-1:0] acs_state,
  output logic          acs_first,
  input  logic [SW-1:0] best_state,
  output logic          sm_we,
  output logic [AW-1:0] sm_waddr,
  output logic [AW-1:0] sm_raddr,
  output logic [SW-1:0] sm_rstate,
  input  logic          sm_rbit,
  output logic          out_valid,
  output logic          out_bit,
  input  logic          out_ready,
  output logic          busy
);

  typedef enum logic [2:0] {IDLE, ACS, BEST, TB, OUT} state_e;

  localparam logic [AW:0]   FILL_FULL = (AW + 1)'(D_TB);
  localparam logic [AW-1:0] LAST_STEP = AW'(D_TB - 2);
  localparam logic [SW-1:0] LAST_ACS  = SW'(NS - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic [SW-1:0] cur_q, cur_d;
  logic [AW-1:0] step_q, step_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [SW-1:0] acs_state_q, acs_state_d;
  logic          acs_en_q, acs_en_d;
  logic          acs_first_q, acs_first_d;
  logic          out_valid_q, out_valid_d;
  logic          out_bit_q, out_bit_d;

  // Handshake-facing status decoded straight from the state register.
  assign in_ready  = (state_q == IDLE) && rst_n && !clear;
  assign busy      = (state_q != IDLE);

  // Every other output is taken directly from a flop.
  assign acs_en    = acs_en_q;
  assign sm_we     = acs_en_q;
  assign acs_state = acs_state_q;
  assign acs_first = acs_first_q;
  assign sm_waddr  = wr_ptr_q;
  assign sm_raddr  = raddr_q;
  assign sm_rstate = cur_q;
  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    cur_d       = cur_q;
    step_d      = step_q;
    raddr_d     = raddr_q;
    acs_state_d = acs_state_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d     = ACS;
          acs_state_d = '0;
        end
      end
      ACS: begin
        if (acs_state_q == LAST_ACS) begin
          state_d     = BEST;
          acs_state_d = '0;
        end else begin
          acs_state_d = acs_state_q + SW'(1);
        end
      end
      BEST: begin
        cur_d  = best_state;
        fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + (AW + 1)'(1);
        if (fill_d == FILL_FULL) begin
          // Traceback starts at the column just written.
          state_d = TB;
          step_d  = '0;
          raddr_d = wr_ptr_q;
        end else begin
          state_d  = IDLE;
          wr_ptr_d = wr_ptr_q + AW'(1);
        end
      end
      TB: begin
        cur_d   = (cur_q << 1) | {{(SW - 1){1'b0}}, sm_rbit};
        step_d  = step_q + AW'(1);
        raddr_d = raddr_q - AW'(1);
        if (step_q == LAST_STEP) state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          state_d  = IDLE;
          wr_ptr_d = wr_ptr_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A synchronous clear wins over everything decided above.
    if (clear) begin
      state_d     = IDLE;
      wr_ptr_d    = '0;
      fill_d      = '0;
      cur_d       = '0;
      step_d      = '0;
      raddr_d     = '0;
      acs_state_d = '0;
    end

    acs_en_d    = (state_d == ACS);
    acs_first_d = (state_d == ACS) && (acs_state_d == '0);
    out_valid_d = (state_d == OUT);
    out_bit_d   = (state_d == OUT) ? cur_d[SW-1] : 1'b0;
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      cur_q       <= '0;
      step_q      <= '0;
      raddr_q     <= '0;
      acs_state_q <= '0;
      acs_en_q    <= 1'b0;
      acs_first_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      cur_q       <= cur_d;
      step_q      <= step_d;
      raddr_q     <= raddr_d;
      acs_state_q <= acs_state_d;
      acs_en_q    <= acs_en_d;
      acs_first_q <= acs_first_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
    end
  end

endmodule

// File: tb/tb_viterbi_seq_ctrl.sv
// tb_viterbi_seq_ctrl: scoreboard bench for the Viterbi sequencing controller.
// A survivor memory is emulated around the DUT. A separate reference copy is
// written at the column the bench expects, and the expected decoded bit is
// traced back from that copy.
module tb_viterbi_seq_ctrl;

  localparam int K    = 5;
  localparam int D_TB = 32;
  localparam int NS   = 16;
  localparam int SW   = 4;
  localparam int AW   = 5;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          clear     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [SW-1:0] best_state = '0;
  logic          in_ready, acs_en, acs_first, sm_we, sm_rbit, out_valid, out_bit, busy;
  logic [SW-1:0] acs_state, sm_rstate;
  logic [AW-1:0] sm_waddr, sm_raddr;

  logic          mem   [D_TB][NS];
  logic          model [D_TB][NS];
  logic [NS-1:0] cur_bits = '0;
  bit            sb_q[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            sym_cnt = 0;
  int            exp_raddr [D_TB];
  logic [SW-1:0] exp_rstate[D_TB];

  always #5 clk = ~clk;

  viterbi_seq_ctrl #(.K(K), .D_TB(D_TB)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .acs_en(acs_en), .acs_state(acs_state), .acs_first(acs_first),
    .best_state(best_state),
    .sm_we(sm_we), .sm_waddr(sm_waddr),
    .sm_raddr(sm_raddr), .sm_rstate(sm_rstate), .sm_rbit(sm_rbit),
    .out_valid(out_valid), .out_bit(out_bit), .out_ready(out_ready),
    .busy(busy)
  );

  // Survivor memory as the ACS unit would write it, read combinationally.
  always @(posedge clk) if (sm_we) mem[sm_waddr][acs_state] <= cur_bits[acs_state];
  assign sm_rbit = mem[sm_raddr][sm_rstate];

  // Reference traceback over the bench's own survivor copy.
  task automatic model_traceback(input int col, input logic [SW-1:0] best, output bit ob);
    logic [SW-1:0] c;
    int r;
    c = best;
    for (int s = 0; s < D_TB - 1; s++) begin
      r = (col - s + D_TB) % D_TB;
      exp_raddr[s]  = r;
      exp_rstate[s] = c;
      c = {c[SW-2:0], model[r][c]};
    end
    ob = c[SW-1];
  endtask

  // Abort the symbol in flight: mode 1 = clear with in_valid, mode 2 = async reset.
  task automatic do_abort(input int mode);
    logic [4:0]  o5;
    logic [21:0] o22;
    if (mode == 1) begin
      clear = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1 clear = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      o5 = {busy, in_ready, out_valid, acs_en, sm_we};
      vectors++;
      if (o5 !== 5'b01000) begin
        miscompares++;
        $display("FAIL clear_to_idle: {busy,in_ready,out_valid,acs_en,sm_we} got %b, required 01000", o5);
      end
    end else begin
      rst_n = 1'b0;
      #1;
      o22 = {acs_en, sm_we, acs_first, out_valid, busy, in_ready,
             acs_state, sm_waddr, sm_raddr, sm_rstate};
      vectors++;
      if (o22 !== '0) begin
        miscompares++;
        $display("FAIL reset_mid_acs_outputs: got %h, required 0", o22);
      end
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        vectors++;
        if ({sm_we, out_valid, busy} !== 3'b000) begin
          miscompares++;
          $display("FAIL reset_abort_quiet cyc=%0d: {sm_we,out_valid,busy} got %b, required 000",
                   i, {sm_we, out_valid, busy});
        end
      end
    end
    sym_cnt = 0;
  endtask

  // Drive one symbol pair and follow it through ACS, BEST, traceback and output.
  task automatic run_symbol(input logic [NS-1:0] bits, input logic [SW-1:0] best,
                            input int hold, input int abort_mode, input int abort_cyc);
    int         col, wait_cnt;
    bit         goes_tb, eb, exp_bit;
    logic [13:0] obs, expv;
    logic [9:0]  obs_tb, exp_tb;
    cur_bits = bits; best_state = best;
    @(negedge clk);
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 100) begin @(negedge clk); wait_cnt++; end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL in_ready_timeout: in_ready got %b, required 1", in_ready);
      return;
    end
    col = sym_cnt % D_TB;
    for (int st = 0; st < NS; st++) model[col][st] = bits[st];
    goes_tb = (sym_cnt >= D_TB - 1);
    if (goes_tb) begin
      model_traceback(col, best, eb);
      if (abort_mode == 0) sb_q.push_back(eb);
    end
    sym_cnt++;
    in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;

    for (int cyc = 1; cyc <= NS + 1; cyc++) begin
      @(negedge clk);
      if (abort_mode != 0 && cyc == abort_cyc) begin do_abort(abort_mode); return; end
      if (cyc <= NS) begin
        obs  = {acs_en, sm_we, acs_first, acs_state, sm_waddr, in_ready, busy};
        expv = {1'b1, 1'b1, (cyc == 1), SW'(cyc - 1), AW'(col), 1'b0, 1'b1};
      end else begin
        obs  = {11'd0, acs_en, sm_we, out_valid};
        expv = '0;
      end
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL acs_seq sym=%0d cyc=%0d: got %h, required %h", sym_cnt - 1, cyc, obs, expv);
      end
    end

    if (!goes_tb) begin
      @(negedge clk);
      vectors++;
      if ({in_ready, busy, out_valid} !== 3'b100) begin
        miscompares++;
        $display("FAIL fill_return sym=%0d: {in_ready,busy,out_valid} got %b, required 100",
                 sym_cnt - 1, {in_ready, busy, out_valid});
      end
      return;
    end

    for (int s = 0; s < D_TB - 1; s++) begin
      @(negedge clk);
      if (abort_mode != 0 && (NS + 2 + s) == abort_cyc) begin do_abort(abort_mode); return; end
      obs_tb = {sm_raddr, sm_rstate, out_valid};
      exp_tb = {AW'(exp_raddr[s]), exp_rstate[s], 1'b0};
      vectors++;
      if (obs_tb !== exp_tb) begin
        miscompares++;
        $display("FAIL traceback sym=%0d step=%0d: {raddr,rstate,out_valid} got %h, required %h",
                 sym_cnt - 1, s, obs_tb, exp_tb);
      end
    end

    @(negedge clk);
    vectors++;
    if ({out_valid, in_ready, acs_en} !== 3'b100) begin
      miscompares++;
      $display("FAIL out_latency sym=%0d: {out_valid,in_ready,acs_en} got %b, required 100",
               sym_cnt - 1, {out_valid, in_ready, acs_en});
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      vectors++;
      if ({out_valid, out_bit, in_ready, sm_we} !== {1'b1, sb_q[0], 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL backpressure h=%0d: {out_valid,out_bit,in_ready,sm_we} got %b, required %b",
                 h, {out_valid, out_bit, in_ready, sm_we}, {1'b1, sb_q[0], 2'b00});
      end
    end
    exp_bit = sb_q.pop_front();
    vectors++;
    if (out_bit !== exp_bit) begin
      miscompares++;
      $display("FAIL out_bit sym=%0d: got %b, required %b", sym_cnt - 1, out_bit, exp_bit);
    end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL out_handshake sym=%0d: {in_ready,out_valid,busy} got %b, required 100",
               sym_cnt - 1, {in_ready, out_valid, busy});
    end
  endtask

  task automatic test_reset();
    logic [21:0] o22;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    o22 = {acs_en, sm_we, acs_first, out_valid, busy, in_ready,
           acs_state, sm_waddr, sm_raddr, sm_rstate};
    vectors++;
    if (o22 !== '0 || out_bit !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h/%b, required 0/0", o22, out_bit);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if ({in_ready, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_release: {in_ready,busy} got %b, required 10", {in_ready, busy});
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < D_TB - 1; i++) run_symbol('0, '0, 0, 0, 0);
  endtask

  task automatic test_first_output();
    run_symbol('0, '0, 0, 0, 0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 8; i++)
      run_symbol(NS'($urandom), SW'($urandom_range(0, NS - 1)), 0, 0, 0);
  endtask

  task automatic test_backpressure();
    run_symbol(NS'($urandom), SW'($urandom_range(0, NS - 1)), 10, 0, 0);
  endtask

  task automatic test_clear_mid_tb();
    run_symbol(NS'($urandom), '0, 0, 1, NS + 7);
    for (int i = 0; i < D_TB - 1; i++) run_symbol('1, '0, 0, 0, 0);
  endtask

  task automatic test_traceback_ones();
    run_symbol('1, '0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_acs();
    run_symbol(NS'($urandom), '0, 0, 2, 5);
  endtask

  initial begin
    for (int c = 0; c < D_TB; c++)
      for (int s = 0; s < NS; s++) begin
        mem[c][s]   = 1'b0;
        model[c][s] = 1'b0;
      end
    test_reset();
    test_fill();
    test_first_output();
    test_wrap();
    test_backpressure();
    test_clear_mid_tb();
    test_traceback_ones();
    test_reset_mid_acs();
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d bits left, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
